fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//   Parametrised fetch stage. Owns the fetch PC and issues in-order requests to instruction memory.
//   Buffers returned instructions in a DEPTH-entry prefetch queue and presents {pcF, instrF} to decode
//   with a valid/stall handshake. Redirects (reset vector, interrupt, branch) flush the queue and squash
//   in-flight responses. Sits between the PC-select logic of decode and the I-side memory port.
// PARAMETERS
//   WIDTH             32            address/data width (bits)
//   DEPTH             4             prefetch queue entries; also max requests in flight (power of 2, >=2)
//   RESET_ADDRESS     32'hbfc00000  boot vector
//   INTERRUPT_ADDRESS 32'hbfc00100  exception vector
// PORTS
//   clk         in   1      clock, rising edge
//   reset       in   1      asynchronous, active-low reset
//   stallF      in   1      decode cannot accept the head instruction this cycle
//   pcsrcFD     in   2      00 reset vector, 01 interrupt vector, 10 sequential, 11 branch target
//   pcnextbrFD  in   WIDTH  branch/jump target, used when pcsrcFD==11
//   imem_req    out  1      request valid
//   imem_addr   out  WIDTH  request address (fetch PC)
//   imem_ready  in   1      memory accepts the request this cycle
//   imem_rvalid in   1      response valid; responses return in request order, >=1 cycle after accept
//   imem_rdata  in   WIDTH  response instruction word
//   validF      out  1      head entry valid
//   pcF         out  WIDTH  PC of head instruction
//   instrF      out  WIDTH  head instruction
//   pcplus4F    out  WIDTH  pcF + 4
// BEHAVIOUR
//   Reset (reset==0): fpc=RESET_ADDRESS; queue empty; inflight=0; drop=0; validF=0; imem_req=0;
//     pcF/instrF=0; pcplus4F=4. Asynchronous assert, synchronous deassert edge.
//   redirect = (pcsrcFD != 2'b10). Target: 00->RESET_ADDRESS, 01->INTERRUPT_ADDRESS, 11->pcnextbrFD.
//   Redirect cycle:
//     - fpc <= target; queue emptied; no pop counted; imem_req forced 0.
//     - drop <= drop + inflight - (imem_rvalid ? 1 : 0); the response arriving that cycle is discarded.
//   Issue: imem_req = !redirect && (count + inflight + drop < DEPTH); imem_addr = fpc.
//     - On imem_req && imem_ready: fpc <= fpc + 4, inflight += 1.
//     - Request held stable (addr unchanged) until accepted or cancelled by redirect.
//   Response:
//     - If drop != 0: drop -= 1, data discarded.
//     - Else: inflight -= 1, enqueue {pc = issue PC, instr = imem_rdata}.
//     - Issue PC is tracked in a DEPTH-entry in-flight PC FIFO, cleared on redirect.
//     - Simultaneous issue and response: counters net (+1 -1).
//   Pop: validF && !stallF && !redirect. Enqueue and pop in the same cycle are both performed.
//   Overflow is impossible by credit rule. A response with inflight==drop==0 is a protocol error:
//     ignored, flagged by assertion.
//   Latency (no bypass): accept at t, response at t+1, validF at t+2. Sustained 1 instr/cycle
//     requires DEPTH>=3 with 1-cycle memory.
//   Pointers: wrap modulo DEPTH. Count width is clog2(DEPTH)+1.
//   pcplus4F wraps modulo 2^WIDTH (e.g. 32'hfffffffc -> 0).
//   Reset mid-operation: all state returns to reset values; in-flight responses after reset are
//     discarded by the protocol-error rule.
// CONFIGURATION
//   FETCH_BYPASS_EN defined:
//     - When the queue is empty, drop==0 and imem_rvalid, the response drives validF/pcF/instrF in the
//       same cycle. If popped that cycle it is not enqueued; otherwise it is enqueued.
//     - Latency: accept at t, consumed at t+1.
//     - Redirect still wins: the bypassed word is discarded.
//   FETCH_BYPASS_EN undefined: outputs come only from queue registers (latency t+2, as above).
// TESTING
//   1. Reset release, imem_ready=1, 1-cycle memory -> addresses bfc00000, bfc00004, ... in order;
//      pcF=bfc00000, pcplus4F=bfc00004 at cycle 2 (cycle 1 with bypass).
//   2. stallF=1 for 10 cycles -> at most DEPTH=4 entries queued plus 0 in flight; imem_req low;
//      head held; on release, 4 consecutive pops with no bubble.
//   3. pcsrcFD=11, pcnextbrFD=80001000 while 3 requests in flight -> next 3 responses dropped;
//      first validF instruction has pcF=80001000.
//   4. pcsrcFD=01 in the same cycle as imem_rvalid and a pop -> queue empty, response discarded,
//      next imem_addr=bfc00100.
//   5. imem_ready toggling 1/0 with 3-cycle memory latency -> instruction stream in PC order,
//      no duplicates/gaps, inflight never exceeds 4.
//   6. reset asserted mid-burst -> outputs return to reset values asynchronously;
//      imem_addr=bfc00000 after release.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: owns the fetch PC, issues in-order I-memory requests and buffers responses in a
// DEPTH-entry prefetch queue. Define FETCH_BYPASS_EN for same-cycle response bypass to decode.
module fetch_queue #(
    parameter int unsigned      WIDTH             = 32,
    parameter int unsigned      DEPTH             = 4,
    parameter logic [WIDTH-1:0] RESET_ADDRESS     = 32'hbfc00000,
    parameter logic [WIDTH-1:0] INTERRUPT_ADDRESS = 32'hbfc00100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stallF,
    input  logic [1:0]       pcsrcFD,
    input  logic [WIDTH-1:0] pcnextbrFD,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ready,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             validF,
    output logic [WIDTH-1:0] pcF,
    output logic [WIDTH-1:0] instrF,
    output logic [WIDTH-1:0] pcplus4F
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = CW + 2;

    logic [WIDTH-1:0] fpc_q, fpc_d;
    logic [CW-1:0]    count_q, count_d, inflight_q, inflight_d, drop_q, drop_d;
    logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d, ipc_rd_q, ipc_rd_d, ipc_wr_q, ipc_wr_d;
    logic [WIDTH-1:0] q_pc_q [DEPTH];
    logic [WIDTH-1:0] q_pc_d [DEPTH];
    logic [WIDTH-1:0] q_instr_q [DEPTH];
    logic [WIDTH-1:0] q_instr_d [DEPTH];
    logic [WIDTH-1:0] ipc_q [DEPTH];
    logic [WIDTH-1:0] ipc_d [DEPTH];

    logic             redirect, credit_ok, issue, rsp_live, rsp_drop, q_empty;
    logic             byp, pop, enq, deq;
    logic [WIDTH-1:0] target;

    always_comb begin
        redirect = (pcsrcFD != 2'b10);
        case (pcsrcFD)
            2'b00:   target = RESET_ADDRESS;
            2'b01:   target = INTERRUPT_ADDRESS;
            default: target = pcnextbrFD;
        endcase

        // Outstanding credits cover queued, in-flight and to-be-dropped words, so the queue never overflows.
        credit_ok = ({2'b00, count_q} + {2'b00, inflight_q} + {2'b00, drop_q}) < SW'(DEPTH);
        imem_req  = reset && !redirect && credit_ok;
        imem_addr = fpc_q;
        issue     = imem_req && imem_ready;

        rsp_live = imem_rvalid && (drop_q == '0) && (inflight_q != '0);
        rsp_drop = imem_rvalid && (drop_q != '0);
        q_empty  = (count_q == '0);
`ifdef FETCH_BYPASS_EN
        byp = q_empty && rsp_live && !redirect;
`else
        byp = 1'b0;
`endif
        validF   = !q_empty || byp;
        pcF      = byp ? ipc_q[ipc_rd_q] : q_pc_q[rd_q];
        instrF   = byp ? imem_rdata : q_instr_q[rd_q];
        pcplus4F = pcF + WIDTH'(4);

        pop = validF && !stallF && !redirect;
        enq = rsp_live && !redirect && !(byp && pop);
        deq = pop && !q_empty;
    end

    always_comb begin
        fpc_d      = fpc_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        ipc_rd_d   = ipc_rd_q;
        ipc_wr_d   = ipc_wr_q;
        q_pc_d     = q_pc_q;
        q_instr_d  = q_instr_q;
        ipc_d      = ipc_q;

        if (redirect) begin
            fpc_d      = target;
            count_d    = '0;
            inflight_d = '0;
            rd_d       = '0;
            wr_d       = '0;
            ipc_rd_d   = '0;
            ipc_wr_d   = '0;
            // Everything still outstanding becomes garbage; a response landing now is discarded too.
            drop_d     = drop_q + inflight_q;
            if (imem_rvalid && ((drop_q != '0) || (inflight_q != '0)))
                drop_d = drop_d - CW'(1);
        end else begin
            if (issue) begin
                fpc_d           = fpc_q + WIDTH'(4);
                ipc_d[ipc_wr_q] = fpc_q;
                ipc_wr_d        = ipc_wr_q + PW'(1);
            end
            if (rsp_live)
                ipc_rd_d = ipc_rd_q + PW'(1);
            if (rsp_drop)
                drop_d = drop_q - CW'(1);
            inflight_d = inflight_q + CW'(issue) - CW'(rsp_live);
            if (enq) begin
                q_pc_d[wr_q]    = ipc_q[ipc_rd_q];
                q_instr_d[wr_q] = imem_rdata;
                wr_d            = wr_q + PW'(1);
            end
            if (deq)
                rd_d = rd_q + PW'(1);
            count_d = count_q + CW'(enq) - CW'(deq);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fpc_q      <= RESET_ADDRESS;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            ipc_rd_q   <= '0;
            ipc_wr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_pc_q[i]    <= '0;
                q_instr_q[i] <= '0;
                ipc_q[i]     <= '0;
            end
        end else begin
            fpc_q      <= fpc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            ipc_rd_q   <= ipc_rd_d;
            ipc_wr_q   <= ipc_wr_d;
            q_pc_q     <= q_pc_d;
            q_instr_q  <= q_instr_d;
            ipc_q      <= ipc_d;
        end
    end

    // A response with nothing outstanding is a memory-side protocol error; it is ignored above.
    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!reset)
        !(imem_rvalid && (inflight_q == '0) && (drop_q == '0)));

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed vector table plus hand sequences against an in-order memory model
// with programmable latency (default build, no bypass).
module tb_fetch_queue;

    logic        clk         = 1'b0;
    logic        reset       = 1'b0;
    logic        stallF      = 1'b0;
    logic [1:0]  pcsrcFD     = 2'b10;
    logic [31:0] pcnextbrFD  = 32'h0;
    logic        imem_ready  = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        validF;
    logic [31:0] pcF, instrF, pcplus4F;

    fetch_queue dut (
        .clk(clk), .reset(reset), .stallF(stallF), .pcsrcFD(pcsrcFD), .pcnextbrFD(pcnextbrFD),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .validF(validF), .pcF(pcF), .instrF(instrF), .pcplus4F(pcplus4F)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } pend_t;
    typedef struct { logic stall; logic req; logic [31:0] addr; logic valid; logic [31:0] pc; } vec_t;

    pend_t       pend[$];
    vec_t        tv[19];
    int          total = 0, bad = 0;
    int          lat = 1, edge_no = 0, max_pend = 0, n_consumed = 0;
    bit          stream_on = 0;
    logic [31:0] exp_pc = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge: samples handshakes, then advances one clock and drives the memory model.
    task automatic advance();
        bit          acc, rsp;
        logic [31:0] a;
        acc = imem_req && imem_ready;
        a   = imem_addr;
        rsp = imem_rvalid;
        if (stream_on && validF && !stallF && pcsrcFD == 2'b10) begin
            chk("stream_pc", pcF, exp_pc);
            chk("stream_instr", instrF, ~exp_pc);
            exp_pc = exp_pc + 32'd4;
            n_consumed++;
        end
        @(posedge clk);
        #1;
        edge_no++;
        if (rsp && pend.size() > 0) void'(pend.pop_front());
        if (acc) pend.push_back('{addr: a, due: edge_no + lat - 1});
        if (pend.size() > max_pend) max_pend = pend.size();
        if (pend.size() > 0 && pend[0].due <= edge_no) begin
            imem_rvalid = 1'b1;
            imem_rdata  = ~pend[0].addr;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        advance();
    endtask

    task automatic do_reset(input int l);
        reset       = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        pend.delete();
        stream_on   = 0;
        pcsrcFD     = 2'b10;
        stallF      = 1'b0;
        imem_ready  = 1'b1;
        lat         = l;
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b1;
        edge_no  = 0;
        max_pend = 0;
    endtask

    // Bounded wait for validF; leaves the caller at a negedge.
    task automatic wait_valid(input string name, output int n);
        n = 0;
        @(negedge clk);
        while (!validF && n < 20) begin
            advance();
            n++;
            @(negedge clk);
        end
        if (!validF) begin
            total++;
            bad++;
            $display("FAIL %s: validF never rose within %0d cycles", name, n);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;

        tv[0]  = '{1'b0, 1'b1, 32'hbfc00000, 1'b0, 32'h0};
        tv[1]  = '{1'b0, 1'b1, 32'hbfc00004, 1'b0, 32'h0};
        tv[2]  = '{1'b0, 1'b1, 32'hbfc00008, 1'b1, 32'hbfc00000};
        tv[3]  = '{1'b0, 1'b1, 32'hbfc0000c, 1'b1, 32'hbfc00004};
        tv[4]  = '{1'b1, 1'b1, 32'hbfc00010, 1'b1, 32'hbfc00008};
        tv[5]  = '{1'b1, 1'b1, 32'hbfc00014, 1'b1, 32'hbfc00008};
        for (int k = 6; k <= 13; k++) tv[k] = '{1'b1, 1'b0, 32'hbfc00018, 1'b1, 32'hbfc00008};
        tv[14] = '{1'b0, 1'b0, 32'hbfc00018, 1'b1, 32'hbfc00008};
        tv[15] = '{1'b0, 1'b1, 32'hbfc00018, 1'b1, 32'hbfc0000c};
        tv[16] = '{1'b0, 1'b1, 32'hbfc0001c, 1'b1, 32'hbfc00010};
        tv[17] = '{1'b0, 1'b1, 32'hbfc00020, 1'b1, 32'hbfc00014};
        tv[18] = '{1'b0, 1'b1, 32'hbfc00024, 1'b1, 32'hbfc00018};

        // Held in reset from time zero
        @(negedge clk);
        chk("rst_validF", validF, 1'b0);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_pcF", pcF, 32'h0);
        chk("rst_instrF", instrF, 32'h0);
        chk("rst_pcplus4F", pcplus4F, 32'h4);

        // Boot stream with a 10-cycle stall, 1-cycle memory
        do_reset(1);
        for (int i = 0; i < 19; i++) begin
            stallF = tv[i].stall;
            @(negedge clk);
            chk($sformatf("vec%0d_req", i), imem_req, tv[i].req);
            chk($sformatf("vec%0d_addr", i), imem_addr, tv[i].addr);
            chk($sformatf("vec%0d_valid", i), validF, tv[i].valid);
            if (tv[i].valid) begin
                chk($sformatf("vec%0d_pcF", i), pcF, tv[i].pc);
                chk($sformatf("vec%0d_instrF", i), instrF, ~tv[i].pc);
                chk($sformatf("vec%0d_pcplus4F", i), pcplus4F, tv[i].pc + 32'd4);
            end
            advance();
        end
        stallF = 1'b0;

        // Branch with three requests in flight, 4-cycle memory
        do_reset(4);
        repeat (3) tick();
        pcsrcFD    = 2'b11;
        pcnextbrFD = 32'h80001000;
        @(negedge clk);
        chk("br_req_forced_low", imem_req, 1'b0);
        advance();
        pcsrcFD = 2'b10;
        @(negedge clk);
        chk("br_req_after", imem_req, 1'b1);
        chk("br_addr_after", imem_addr, 32'h80001000);
        chk("br_valid_k4", validF, 1'b0);
        advance();
        wait_valid("br_wait", n);
        chk("br_latency", n, 4);
        chk("br_first_pcF", pcF, 32'h80001000);
        chk("br_first_instrF", instrF, ~32'h80001000);

        // Interrupt redirect coinciding with a response and a would-be pop
        do_reset(1);
        repeat (2) tick();
        pcsrcFD = 2'b01;
        @(negedge clk);
        chk("irq_valid_before", validF, 1'b1);
        chk("irq_req_forced_low", imem_req, 1'b0);
        advance();
        pcsrcFD = 2'b10;
        @(negedge clk);
        chk("irq_queue_empty", validF, 1'b0);
        chk("irq_req", imem_req, 1'b1);
        chk("irq_addr", imem_addr, 32'hbfc00100);
        advance();
        wait_valid("irq_wait", n);
        chk("irq_latency", n, 1);
        chk("irq_first_pcF", pcF, 32'hbfc00100);
        chk("irq_first_instrF", instrF, ~32'hbfc00100);

        // Toggling ready, 3-cycle memory, occasional stalls: in-order gap-free stream
        do_reset(3);
        exp_pc     = 32'hbfc00000;
        n_consumed = 0;
        stream_on  = 1;
        for (int i = 0; i < 80; i++) begin
            imem_ready = (i % 2 == 0);
            stallF     = (i % 7 == 3);
            tick();
        end
        stream_on  = 0;
        stallF     = 1'b0;
        imem_ready = 1'b1;
        chk("stream_progress", (n_consumed >= 20), 1'b1);
        chk("stream_max_outstanding", (max_pend <= 4), 1'b1);

        // pcplus4F wrap at the top of the address space
        do_reset(1);
        pcsrcFD    = 2'b11;
        pcnextbrFD = 32'hfffffffc;
        @(negedge clk);
        chk("wrap_req_forced_low", imem_req, 1'b0);
        advance();
        pcsrcFD = 2'b10;
        wait_valid("wrap_wait", n);
        chk("wrap_pcF", pcF, 32'hfffffffc);
        chk("wrap_pcplus4F", pcplus4F, 32'h0);
        advance();
        @(negedge clk);
        chk("wrap_next_pcF", pcF, 32'h0);
        chk("wrap_next_pcplus4F", pcplus4F, 32'h4);
        advance();

        // Asynchronous reset in the middle of a burst
        do_reset(1);
        repeat (5) tick();
        @(negedge clk);
        chk("mid_valid_before", validF, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_validF", validF, 1'b0);
        chk("async_req", imem_req, 1'b0);
        chk("async_pcF", pcF, 32'h0);
        chk("async_instrF", instrF, 32'h0);
        chk("async_pcplus4F", pcplus4F, 32'h4);
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        pend.delete();
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b1;
        edge_no = 0;
        @(negedge clk);
        chk("post_rst_req", imem_req, 1'b1);
        chk("post_rst_addr", imem_addr, 32'hbfc00000);
        chk("post_rst_valid", validF, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
